// File: rtl/ipg_req_proc_if.sv
// IPG request processor bus: received block stream in, reply chunk push out.
interface ipg_req_proc_if;
  logic        rx_valid;
  logic [1:0]  rx_hdr;
  logic [63:0] rx_data;
  logic        memq_full;
  logic [63:0] ipg_reply_chunk;
  logic        memq_write;

  // Block source / reply-queue side
  modport master (
    output rx_valid, rx_hdr, rx_data, memq_full,
    input  ipg_reply_chunk, memq_write
  );

  // Request processor side
  modport slave (
    input  rx_valid, rx_hdr, rx_data, memq_full,
    output ipg_reply_chunk, memq_write
  );
endinterface

// File: rtl/ipg_req_proc.sv
// ipg_req_proc: executes IPG read/write request blocks against a small
// register memory and emits one reply chunk per accepted request.
// Optional feature macro: IPG_REQ_WRITE_EN (opcode 02 writes memory).
// Without it the memory is read-only zeros and opcode 02 is unsupported.
module ipg_req_proc #(
  parameter logic [7:0] REQ_BT    = 8'hA5,
  parameter logic [7:0] RPL_BT    = 8'hC3,
  parameter int         MEM_DEPTH = 16,
  parameter int         QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  ipg_req_proc_if.slave     bus,
  output logic              busy,
  output logic [15:0]       req_drop_cnt
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, EMIT} state_t;

  state_t        state_q, state_d;
  logic [55:0]   q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt;
  logic          q_full, q_empty, req_det, push, pop;
  logic [55:0]   wk;
  logic [63:0]   rply;
  logic          mw_q, strobe_d;
  logic [7:0]    op, tag, addr, status;
  logic [31:0]   wdata, rdat, rd_word;
  logic          addr_ok;

  assign req_det = bus.rx_valid && (bus.rx_hdr == 2'b01) && (bus.rx_data[7:0] == REQ_BT);
  assign q_full  = (q_cnt == CW'(QDEPTH));
  assign q_empty = (q_cnt == '0);
  // A pop in the same cycle frees a slot, so a full queue still accepts
  assign push    = req_det && (!q_full || pop);
  assign busy    = (state_q != IDLE) || !q_empty;

  assign op    = wk[7:0];
  assign tag   = wk[15:8];
  assign addr  = wk[23:16];
  assign wdata = wk[55:24];
  assign addr_ok = ({24'd0, addr} < 32'(MEM_DEPTH));

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

  // Request FIFO storage (only fields above the block-type byte)
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= bus.rx_data[63:8];
  end

  // Saturating count of requests lost to a full queue
  always_ff @(posedge clk) begin
    if (reset) req_drop_cnt <= '0;
    else if (req_det && !push && (req_drop_cnt != 16'hFFFF))
      req_drop_cnt <= req_drop_cnt + 16'd1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, queue pop and reply strobe request
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: if (!q_empty) begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: state_d = EMIT;
      EMIT: if (!bus.memq_full) begin
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working register holds the request being executed
  always_ff @(posedge clk) begin
    if (reset)    wk <= '0;
    else if (pop) wk <= q_mem[rd_ptr];
  end

`ifdef IPG_REQ_WRITE_EN
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] addr_idx;
  logic          wr_en;
  assign addr_idx = addr[AW-1:0];
  assign rd_word  = mem[addr_idx];

  // Register memory; a write lands at the end of its EXEC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[addr_idx] <= wdata;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata;
  assign rd_word      = 32'h0;
`endif

  // Decode: opcode errors take precedence over address errors
  always_comb begin
    status = 8'h00;
    rdat   = 32'h0;
`ifdef IPG_REQ_WRITE_EN
    wr_en  = 1'b0;
`endif
    if (op == 8'h01) begin
      if (!addr_ok) status = 8'h02;
      else          rdat   = rd_word;
    end
`ifdef IPG_REQ_WRITE_EN
    else if (op == 8'h02) begin
      if (!addr_ok) status = 8'h02;
      else begin
        rdat  = wdata;
        wr_en = (state_q == EXEC);
      end
    end
`endif
    else status = 8'h01;
  end

  // Reply register: formed in EXEC, held stable through EMIT
  always_ff @(posedge clk) begin
    if (reset)                rply <= '0;
    else if (state_q == EXEC) rply <= {rdat, addr, tag, status, RPL_BT};
  end

  // Registered push strobe, one cycle per reply
  always_ff @(posedge clk) begin
    if (reset) mw_q <= 1'b0;
    else       mw_q <= strobe_d;
  end

  assign bus.ipg_reply_chunk = rply;
  assign bus.memq_write      = mw_q;
endmodule

// File: tb/tb_ipg_req_proc.sv
// Self-checking bench for ipg_req_proc: vector table plus hand sequences for
// latency, backpressure, overflow and mid-operation reset. Replies are
// checked against a scoreboard queue filled when requests are driven.
module tb_ipg_req_proc;
`ifdef IPG_REQ_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] req_drop_cnt;
  ipg_req_proc_if bus();

  ipg_req_proc dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .busy         (busy),
    .req_drop_cnt (req_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  hdr;
    logic [7:0]  bt, op, tag, addr;
    logic [31:0] wdata;
    logic        exp_vld;
    logic [7:0]  exp_st;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vt [14];
  logic [63:0] sb [$];
  logic [63:0] exp_r;
  int          n_chk = 0, n_fail = 0, n_rply = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rp(input logic [31:0] d, input logic [7:0] a, t, s);
    return {d, a, t, s, 8'hC3};
  endfunction

  task automatic send(input logic [1:0] hdr, input logic [63:0] data,
                      input logic exp_vld, input logic [63:0] exp_rply);
    bus.rx_valid = 1'b1;
    bus.rx_hdr   = hdr;
    bus.rx_data  = data;
    if (exp_vld) sb.push_back(exp_rply);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_hdr   = 2'b00;
    bus.rx_data  = '0;
  endtask

  task automatic rd(input logic [7:0] tag, addr, input logic [31:0] exp_d, input logic exp_vld);
    send(2'b01, {32'h0, addr, tag, 8'h01, 8'hA5}, exp_vld, rp(exp_d, addr, tag, 8'h00));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || bus.memq_write || sb.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for idle, %0d replies outstanding", nm, sb.size());
      sb.delete();
    end
  endtask

  // Reply monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset && bus.memq_write) begin
      n_rply++;
      chk("strobe_while_full", {63'd0, bus.memq_full}, 64'd0);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_reply: got %h expected none", bus.ipg_reply_chunk);
      end else begin
        exp_r = sb.pop_front();
        chk("reply_chunk", bus.ipg_reply_chunk, exp_r);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    vt[0]  = '{2'b01, 8'hA5, 8'h02, 8'h01, 8'h05, 32'hDEADBEEF, 1'b1, WE ? 8'h00 : 8'h01, WE ? 32'hDEADBEEF : 32'h0};
    vt[1]  = '{2'b01, 8'hA5, 8'h01, 8'h02, 8'h05, 32'h0,        1'b1, 8'h00, WE ? 32'hDEADBEEF : 32'h0};
    vt[2]  = '{2'b01, 8'hA5, 8'h7F, 8'h03, 8'h02, 32'h0,        1'b1, 8'h01, 32'h0};
    vt[3]  = '{2'b01, 8'hA5, 8'h01, 8'h04, 8'd16, 32'h0,        1'b1, 8'h02, 32'h0};
    vt[4]  = '{2'b10, 8'hA5, 8'h01, 8'h05, 8'h03, 32'h0,        1'b0, 8'h00, 32'h0};
    vt[5]  = '{2'b01, 8'h5A, 8'h01, 8'h06, 8'h03, 32'h0,        1'b0, 8'h00, 32'h0};
    vt[6]  = '{2'b01, 8'hA5, 8'h02, 8'h08, 8'd15, 32'h12345678, 1'b1, WE ? 8'h00 : 8'h01, WE ? 32'h12345678 : 32'h0};
    vt[7]  = '{2'b01, 8'hA5, 8'h01, 8'h09, 8'd15, 32'h0,        1'b1, 8'h00, WE ? 32'h12345678 : 32'h0};
    vt[8]  = '{2'b01, 8'hA5, 8'h02, 8'h0A, 8'd200, 32'hCAFEF00D, 1'b1, WE ? 8'h02 : 8'h01, 32'h0};
    vt[9]  = '{2'b01, 8'hA5, 8'h00, 8'h0B, 8'h01, 32'h0,        1'b1, 8'h01, 32'h0};
    vt[10] = '{2'b01, 8'hA5, 8'h01, 8'h0C, 8'h00, 32'h0,        1'b1, 8'h00, 32'h0};
    vt[11] = '{2'b01, 8'hA5, 8'h03, 8'h0D, 8'h04, 32'h55AA55AA, 1'b1, 8'h01, 32'h0};
    vt[12] = '{2'b01, 8'hA5, 8'h01, 8'h0E, 8'd255, 32'h0,       1'b1, 8'h02, 32'h0};
    vt[13] = '{2'b00, 8'hA5, 8'h01, 8'h0F, 8'h01, 32'h0,        1'b0, 8'h00, 32'h0};

    bus.rx_valid = 1'b0; bus.rx_hdr = 2'b00; bus.rx_data = '0; bus.memq_full = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_chunk", bus.ipg_reply_chunk, 64'd0);
    chk("rst_memq_write", {63'd0, bus.memq_write}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_drop_cnt", {48'd0, req_drop_cnt}, 64'd0);

    // Latency: push at edge k, strobe visible only after edge k+3
    rd(8'h07, 8'h03, 32'h0, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_edge_k+%0d", e), {63'd0, bus.memq_write}, {63'd0, e == 3});
    end
    wait_idle("latency");

    // Vector table, one request at a time
    for (int i = 0; i < 14; i++) begin
      rb = n_rply;
      send(vt[i].hdr, {vt[i].wdata, vt[i].addr, vt[i].tag, vt[i].op, vt[i].bt}, vt[i].exp_vld,
           rp(vt[i].exp_data, vt[i].addr, vt[i].tag, vt[i].exp_st));
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_reply_count", i), 64'(n_rply - rb), {63'd0, vt[i].exp_vld});
    end

    // Backpressure: reply held stable in EMIT while the queue is full
    bus.memq_full = 1'b1;
    rd(8'h14, 8'd15, WE ? 32'h12345678 : 32'h0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rb = n_rply;
    for (int c = 0; c < 10; c++) begin
      chk("bp_chunk_stable", bus.ipg_reply_chunk, rp(WE ? 32'h12345678 : 32'h0, 8'd15, 8'h14, 8'h00));
      chk("bp_no_strobe", {63'd0, bus.memq_write}, 64'd0);
      @(posedge clk); #1;
    end
    bus.memq_full = 1'b0;
    wait_idle("backpressure");
    chk("bp_reply_count", 64'(n_rply - rb), 64'd1);

    // Overflow: 10 back-to-back requests, only 5 fit
    bus.memq_full = 1'b1;
    rb = n_rply;
    for (int i = 0; i < 10; i++)
      rd(8'(8'h30 + i), 8'h05, WE ? 32'hDEADBEEF : 32'h0, i < 5);
    chk("ovf_drop_cnt", {48'd0, req_drop_cnt}, 64'd5);
    chk("ovf_busy", {63'd0, busy}, 64'd1);
    bus.memq_full = 1'b0;
    wait_idle("overflow");
    chk("ovf_reply_count", 64'(n_rply - rb), 64'd5);

    // Reset while executing with requests still queued
    rb = n_rply;
    rd(8'h40, 8'h05, 32'h0, 1'b0);
    rd(8'h41, 8'd15, 32'h0, 1'b0);
    bus.rx_valid = 1'b1; bus.rx_hdr = 2'b01; bus.rx_data = {32'h0, 8'h05, 8'h42, 8'h01, 8'hA5};
    reset = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    chk("mrst_chunk", bus.ipg_reply_chunk, 64'd0);
    chk("mrst_memq_write", {63'd0, bus.memq_write}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("mrst_no_replies", 64'(n_rply - rb), 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_drop_cnt", {48'd0, req_drop_cnt}, 64'd0);
    rd(8'h43, 8'h05, 32'h0, 1'b1);
    wait_idle("mrst_read5");
    rd(8'h44, 8'd15, 32'h0, 1'b1);
    wait_idle("mrst_read15");
    chk("mrst_reply_count", 64'(n_rply - rb), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
